// File: rtl/rs_latch_driver_pkg.sv
// Shared types and encodings for the RS latch driver: FSM states and the
// Q value expected back from the latch after each command.
package rs_latch_driver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic Q_AFTER_SET   = 1'b1;
  localparam logic Q_AFTER_RESET = 1'b0;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/rs_latch_driver_debounce_sync.sv
// One button channel: 2-flop synchronizer, stable-count debouncer and a
// registered rising-edge request of the debounced level.
module rs_latch_driver_debounce_sync
  import rs_latch_driver_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic [CNT_W-1:0]       cnt;
  logic                   deb;
  logic                   deb_d;
  logic                   armed;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // A button held through reset must be seen released before it can command,
  // so a level that was already high when reset lifted issues no request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      valid_q <= '0;
      cnt     <= '0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      armed   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
      valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      if (level == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= level;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      deb_d <= deb;
      armed <= armed | (valid_q[SYNC_STAGES-1] & ~level);
      rise  <= deb & ~deb_d & armed;
    end
  end

endmodule

// File: rtl/rs_latch_driver.sv
// Turns two bouncy buttons into mutually exclusive fixed-width S/R pulses for
// a NOR latch, then checks the latch Q after each command (sticky ERR).
module rs_latch_driver
  import rs_latch_driver_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned HOLDOFF_CYCLES  = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic BTN_SET,
  input  logic BTN_RESET,
  input  logic Q_FB,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic ERR
);

  logic             rise_set;
  logic             rise_reset;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             exp_q;
  logic             exp_n;
  logic             err_n;
  logic             s_n;
  logic             r_n;
  logic             busy_n;

  rs_latch_driver_debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (BTN_SET),
    .rise   (rise_set)
  );

  rs_latch_driver_debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_reset (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (BTN_RESET),
    .rise   (rise_reset)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      exp_q <= Q_AFTER_RESET;
      S     <= 1'b0;
      R     <= 1'b0;
      BUSY  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      exp_q <= exp_n;
      S     <= s_n;
      R     <= r_n;
      BUSY  <= busy_n;
      ERR   <= err_n;
    end
  end

  // Outputs are decoded from the next state so S/R/BUSY line up with it;
  // one-hot decoding of a single state keeps S and R exclusive.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exp_n   = exp_q;
    err_n   = ERR;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise_reset) begin
          state_n = PULSE_R;
          exp_n   = Q_AFTER_RESET;
        end else if (rise_set) begin
          state_n = PULSE_S;
          exp_n   = Q_AFTER_SET;
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (Q_FB != exp_q) err_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
    s_n    = (state_n == PULSE_S);
    r_n    = (state_n == PULSE_R);
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_rs_latch_driver.sv
// Bench for rs_latch_driver: directed button sequences against a NOR latch
// model, with a timeline-based reference of the expected S/R/BUSY/ERR.
module tb_rs_latch_driver;

  localparam int DB = 4;
  localparam int P  = 2;
  localparam int H  = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_set;
  logic btn_reset;
  logic q_fb;
  logic s, r, busy, err;

  rs_latch_driver #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (P),
    .HOLDOFF_CYCLES (H),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .BTN_SET  (btn_set),
    .BTN_RESET(btn_reset),
    .Q_FB     (q_fb),
    .S        (s),
    .R        (r),
    .BUSY     (busy),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  // Behavioural NOR latch fed by the DUT, with an override to fake a stuck Q.
  logic latch_q  = 1'b0;
  logic force_q0 = 1'b0;
  always @(s or r) begin
    if (s === 1'b1 && r !== 1'b1) latch_q = 1'b1;
    else if (r === 1'b1 && s !== 1'b1) latch_q = 1'b0;
  end
  assign q_fb = force_q0 ? 1'b0 : latch_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: per-channel debounced level from runs of differing samples,
  // then a command timeline (start edge, pulse window, busy window, check edge).
  int since_rst = 0;
  bit p0[2], p1[2], mdeb[2], armed[2];
  int run[2];
  int req_edge[2];
  bit act, kind_set, m_idle;
  int start;
  bit m_s, m_r, m_busy, m_err;

  always @(posedge clk) begin
    cyc++;
    if (reset_n !== 1'b1) begin
      since_rst = 0;
      for (int ch = 0; ch < 2; ch++) begin
        p0[ch] = 0; p1[ch] = 0; mdeb[ch] = 0; armed[ch] = 0;
        run[ch] = 0; req_edge[ch] = -100;
      end
      act = 0; m_s = 0; m_r = 0; m_busy = 0; m_err = 0;
    end else begin
      since_rst++;
      m_idle = !act;
      if (act && cyc == start + P + H) begin
        if (q_fb !== (kind_set ? 1'b1 : 1'b0)) m_err = 1;
        act = 0;
      end
      if (m_idle) begin
        if (req_edge[1] == cyc) begin
          act = 1; kind_set = 0; start = cyc;
        end else if (req_edge[0] == cyc) begin
          act = 1; kind_set = 1; start = cyc;
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        bit b, sync_old, rose;
        b = (ch == 0) ? btn_set : btn_reset;
        sync_old = p1[ch];
        p1[ch] = p0[ch];
        p0[ch] = b;
        rose = 0;
        if (sync_old != mdeb[ch]) begin
          run[ch]++;
          if (run[ch] == DB) begin
            mdeb[ch] = sync_old;
            run[ch]  = 0;
            rose     = sync_old;
          end
        end else begin
          run[ch] = 0;
        end
        if (since_rst >= 3 && !sync_old) armed[ch] = 1;
        if (rose && armed[ch]) req_edge[ch] = cyc + 2;
      end
      m_s    = act && kind_set && (cyc < start + P);
      m_r    = act && !kind_set && (cyc < start + P);
      m_busy = act;
    end
  end

  bit cmp_en = 0;
  int s_hi = 0, r_hi = 0, busy_hi = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("S", s, m_s);
      check("R", r, m_r);
      check("BUSY", busy, m_busy);
      check("ERR", err, m_err);
      check("S_and_R", s & r, 0);
      if (s === 1'b1) s_hi++;
      if (r === 1'b1) r_hi++;
      if (busy === 1'b1) busy_hi++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    s_hi = 0; r_hi = 0; busy_hi = 0;
  endtask

  int t, first_s, last_s;

  initial begin
    reset_n = 0; btn_set = 1; btn_reset = 1;

    // 1: reset with both buttons high, release with them still high
    @(posedge clk); cmp_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk); reset_n = 1; clear_counts();
    tick(20);
    check("held_through_reset_s", s_hi, 0);
    check("held_through_reset_r", r_hi, 0);
    btn_set = 0; btn_reset = 0;
    tick(12);

    // 2: clean set press, latency and pulse width
    clear_counts();
    btn_set = 1; t = cyc + 1; first_s = -1; last_s = -1;
    repeat (12) begin
      @(posedge clk); #1;
      if (s === 1'b1) begin
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
      end
    end
    check("set_first_s_edge", first_s, t + 7);
    check("set_last_s_edge", last_s, t + 8);
    check("set_busy_cycles", busy_hi, 4);
    check("set_r_cycles", r_hi, 0);
    check("set_q_fb", q_fb, 1);
    check("set_err", err, 0);
    @(negedge clk); btn_set = 0;
    tick(12);
    check("release_no_cmd", busy_hi, 4);

    // 3: bouncing input and a 3-sample glitch are filtered
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      btn_set = ~btn_set;
      tick(2);
    end
    tick(10);
    btn_set = 1; tick(3); btn_set = 0;
    tick(12);
    check("bounce_s", s_hi, 0);
    check("bounce_busy", busy_hi, 0);

    // 4: simultaneous requests, reset wins
    clear_counts();
    btn_set = 1; btn_reset = 1;
    tick(12);
    check("both_r_cycles", r_hi, 2);
    check("both_s_cycles", s_hi, 0);
    btn_set = 0; btn_reset = 0;
    tick(12);
    check("both_q_fb", q_fb, 0);

    // 5: stuck Q during a set raises sticky ERR
    force_q0 = 1; btn_set = 1;
    tick(12);
    check("stuck_err", err, 1);
    btn_set = 0; force_q0 = 0;
    tick(12);
    btn_reset = 1; tick(12); btn_reset = 0; tick(12);
    btn_set = 1; tick(12); btn_set = 0; tick(12);
    check("sticky_q_fb", q_fb, 1);
    check("sticky_err", err, 1);
    reset_n = 0; tick(1);
    check("err_cleared", err, 0);
    reset_n = 1; tick(4);

    // 6a: reset during the first PULSE_S cycle
    btn_set = 1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_pulse_s_on", s, 1);
    @(negedge clk); reset_n = 0;
    @(posedge clk); #1;
    check("mid_pulse_s_off", s, 0);
    check("mid_pulse_busy_off", busy, 0);
    @(negedge clk); reset_n = 1; btn_set = 0;
    tick(12);

    // 6b: bounce on the held set button and a reset request while busy
    clear_counts();
    btn_set = 1; tick(2);
    btn_reset = 1; tick(6);
    btn_set = 0; tick(2);
    btn_set = 1; tick(6);
    btn_set = 0; btn_reset = 0;
    tick(14);
    check("busy_drop_s_cycles", s_hi, 2);
    check("busy_drop_r_cycles", r_hi, 0);
    check("busy_drop_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
